// File: rtl/cpu_sequencer_pkg.sv
// Shared opcode and control-state codes for the CPU sequencer and its decoder.
// OP_JCS/OP_JCC are only legal when the design is built with CPU_SEQ_CARRY_EN.
package cpu_sequencer_pkg;

    localparam int OP_NOP = 0;
    localparam int OP_LDA = 1;
    localparam int OP_ADD = 2;
    localparam int OP_SUB = 3;
    localparam int OP_STA = 4;
    localparam int OP_OUT = 5;
    localparam int OP_JMP = 6;
    localparam int OP_JEZ = 7;
    localparam int OP_JNZ = 8;
    localparam int OP_JCS = 9;
    localparam int OP_JCC = 10;
    localparam int OP_HLT = 15;

    localparam int STATE_FETCH_PC   = 0;
    localparam int STATE_FETCH_INST = 1;
    localparam int STATE_LOAD_ADDR  = 2;
    localparam int STATE_RAM_A      = 3;
    localparam int STATE_STORE_A    = 4;
    localparam int STATE_RAM_B      = 5;
    localparam int STATE_ADD        = 6;
    localparam int STATE_SUB        = 7;
    localparam int STATE_OUT_A      = 8;
    localparam int STATE_JUMP       = 9;
    localparam int STATE_SKIP_JUMP  = 10;
    localparam int STATE_HALT       = 11;
    localparam int STATE_NEXT       = 12;

    // Micro-cycle at which flags are sampled and illegal opcodes are flagged.
    localparam int CYC_EXEC = 3;

    function automatic logic is_mem_op(input int op);
        return (op == OP_LDA) || (op == OP_STA) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/cpu_seq_decode.sv
// Combinational next-state decode: (target cycle, opcode, flags) -> control state, illegal.
// CPU_SEQ_CARRY_EN enables the carry-conditioned jumps OP_JCS/OP_JCC.
module cpu_seq_decode
    import cpu_sequencer_pkg::*;
#(
    parameter int unsigned OP_W    = 4,
    parameter int unsigned STATE_W = 4,
    parameter int unsigned CYC_W   = 3
) (
    input  logic [CYC_W-1:0]   next_cycle,
    input  logic [OP_W-1:0]    opcode,
    input  logic               eq_zero,
    input  logic               carry,
    output logic [STATE_W-1:0] next_state,
    output logic               illegal
);

    int   nc;
    int   op;
    int   st;
    logic legal;
    logic cond_jump;
    logic taken;

`ifndef CPU_SEQ_CARRY_EN
    logic unused_carry;
    assign unused_carry = carry;
`endif

    always_comb begin
        nc        = int'(next_cycle);
        op        = int'(opcode);
        legal     = 1'b0;
        cond_jump = 1'b0;
        taken     = 1'b0;
        case (op)
            OP_NOP, OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_OUT, OP_HLT: legal = 1'b1;
            OP_JMP: begin
                legal     = 1'b1;
                cond_jump = 1'b1;
                taken     = 1'b1;
            end
            OP_JEZ: begin
                legal     = 1'b1;
                cond_jump = 1'b1;
                taken     = eq_zero;
            end
            OP_JNZ: begin
                legal     = 1'b1;
                cond_jump = 1'b1;
                taken     = ~eq_zero;
            end
`ifdef CPU_SEQ_CARRY_EN
            OP_JCS: begin
                legal     = 1'b1;
                cond_jump = 1'b1;
                taken     = carry;
            end
            OP_JCC: begin
                legal     = 1'b1;
                cond_jump = 1'b1;
                taken     = ~carry;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        st = STATE_NEXT;
        case (nc)
            0: st = STATE_FETCH_PC;
            1: st = STATE_FETCH_INST;
            2: begin
                if (op == OP_HLT) begin
                    st = STATE_HALT;
                end else if (op == OP_OUT) begin
                    st = STATE_OUT_A;
                end else begin
                    st = STATE_FETCH_PC;
                end
            end
            3: begin
                // Illegal opcodes fall through to NEXT and behave as NOP.
                if (!legal) begin
                    st = STATE_NEXT;
                end else if (cond_jump) begin
                    st = taken ? STATE_JUMP : STATE_SKIP_JUMP;
                end else if (is_mem_op(op)) begin
                    st = STATE_LOAD_ADDR;
                end else begin
                    st = STATE_NEXT;
                end
            end
            4: begin
                if (legal && cond_jump) begin
                    st = STATE_NEXT;
                end else if (op == OP_LDA) begin
                    st = STATE_RAM_A;
                end else if (op == OP_STA) begin
                    st = STATE_STORE_A;
                end else if ((op == OP_ADD) || (op == OP_SUB)) begin
                    st = STATE_RAM_B;
                end else begin
                    st = STATE_NEXT;
                end
            end
            5: begin
                if (op == OP_ADD) begin
                    st = STATE_ADD;
                end else if (op == OP_SUB) begin
                    st = STATE_SUB;
                end else begin
                    st = STATE_NEXT;
                end
            end
            default: st = STATE_NEXT;
        endcase
    end

    assign next_state = STATE_W'(st);
    assign illegal    = ~legal;

endmodule

// File: rtl/cpu_sequencer.sv
// Self-timed instruction sequencer: state/cycle registers, halt/resume, watchdog and sticky err.
// Build with CPU_SEQ_CARRY_EN to make OP_JCS/OP_JCC legal carry-conditioned jumps.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int unsigned OP_W       = 4,
    parameter int unsigned STATE_W    = 4,
    parameter int unsigned MAX_CYCLES = 8,
    parameter int unsigned CYC_W      = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_W-1:0]    opcode,
    input  logic               eq_zero,
    input  logic               carry,
    input  logic               resume,
    output logic [STATE_W-1:0] state,
    output logic [CYC_W-1:0]   cycle,
    output logic               instr_done,
    output logic               halted,
    output logic               err
);

    localparam logic [STATE_W-1:0] S_FETCH_PC = STATE_W'(STATE_FETCH_PC);
    localparam logic [STATE_W-1:0] S_HALT     = STATE_W'(STATE_HALT);
    localparam logic [STATE_W-1:0] S_NEXT     = STATE_W'(STATE_NEXT);
    localparam logic [CYC_W-1:0]   CYC_LAST   = CYC_W'(MAX_CYCLES - 1);
    localparam logic [CYC_W-1:0]   CYC_SAMPLE = CYC_W'(CYC_EXEC);

    logic [STATE_W-1:0] state_q, state_d, dec_state;
    logic [CYC_W-1:0]   cycle_q, cycle_d, cycle_inc;
    logic               err_q, err_d;
    logic               dec_illegal;

    assign cycle_inc = cycle_q + CYC_W'(1);

    cpu_seq_decode #(
        .OP_W    (OP_W),
        .STATE_W (STATE_W),
        .CYC_W   (CYC_W)
    ) u_decode (
        .next_cycle (cycle_inc),
        .opcode     (opcode),
        .eq_zero    (eq_zero),
        .carry      (carry),
        .next_state (dec_state),
        .illegal    (dec_illegal)
    );

    always_comb begin
        state_d = state_q;
        cycle_d = cycle_q;
        err_d   = err_q;
        if (state_q == S_NEXT) begin
            state_d = S_FETCH_PC;
            cycle_d = '0;
        end else if (state_q == S_HALT) begin
            if (resume) begin
                state_d = S_NEXT;
                cycle_d = cycle_inc;
            end
        end else if (cycle_q == CYC_LAST) begin
            // Watchdog: abandon the instruction and rewind the counter before it can wrap.
            state_d = S_NEXT;
            cycle_d = '0;
            err_d   = 1'b1;
        end else begin
            state_d = dec_state;
            cycle_d = cycle_inc;
            if ((cycle_inc == CYC_SAMPLE) && dec_illegal) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH_PC;
            cycle_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cycle_q <= cycle_d;
            err_q   <= err_d;
        end
    end

    assign state      = state_q;
    assign cycle      = cycle_q;
    assign err        = err_q;
    assign instr_done = (state_q == S_NEXT);
    assign halted     = (state_q == S_HALT);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Table-driven bench for cpu_sequencer: per-clock state/cycle/err vectors plus hand-written
// sequences for async reset, instr_done timing and the watchdog (second instance, MAX_CYCLES=5).
module tb_cpu_sequencer;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LDA = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_STA = 4'd4;
    localparam logic [3:0] OP_OUT = 4'd5;
    localparam logic [3:0] OP_JMP = 4'd6;
    localparam logic [3:0] OP_JEZ = 4'd7;
    localparam logic [3:0] OP_JNZ = 4'd8;
    localparam logic [3:0] OP_JCS = 4'd9;
    localparam logic [3:0] OP_JCC = 4'd10;
    localparam logic [3:0] OP_BAD = 4'd12;
    localparam logic [3:0] OP_HLT = 4'd15;

    localparam logic [3:0] S_FP = 4'd0;
    localparam logic [3:0] S_FI = 4'd1;
    localparam logic [3:0] S_LA = 4'd2;
    localparam logic [3:0] S_RA = 4'd3;
    localparam logic [3:0] S_SA = 4'd4;
    localparam logic [3:0] S_RB = 4'd5;
    localparam logic [3:0] S_AD = 4'd6;
    localparam logic [3:0] S_SB = 4'd7;
    localparam logic [3:0] S_OA = 4'd8;
    localparam logic [3:0] S_JP = 4'd9;
    localparam logic [3:0] S_SK = 4'd10;
    localparam logic [3:0] S_HT = 4'd11;
    localparam logic [3:0] S_NX = 4'd12;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] opcode;
    logic       eq_zero, carry, resume;
    logic [3:0] state, wd_state;
    logic [2:0] cycle, wd_cycle;
    logic       instr_done, halted, err;
    logic       wd_done, wd_halted, wd_err;

    always #5 clk = ~clk;

    cpu_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .eq_zero    (eq_zero),
        .carry      (carry),
        .resume     (resume),
        .state      (state),
        .cycle      (cycle),
        .instr_done (instr_done),
        .halted     (halted),
        .err        (err)
    );

    cpu_sequencer #(.MAX_CYCLES(5)) dut_wd (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .eq_zero    (eq_zero),
        .carry      (carry),
        .resume     (resume),
        .state      (wd_state),
        .cycle      (wd_cycle),
        .instr_done (wd_done),
        .halted     (wd_halted),
        .err        (wd_err)
    );

    typedef struct {
        logic [3:0] op;
        logic       ez;
        logic       cy;
        logic       rs;
        logic [3:0] st;
        logic [2:0] cyc;
        logic       er;
    } vec_t;

    vec_t vq[$];
    int   done_at[$];
    int   n_vec = 0;
    int   n_bad = 0;
    logic exp_err = 1'b0;

    function automatic void push(input logic [3:0] op, input logic ez, input logic cy,
                                 input logic rs, input logic [3:0] st, input logic [2:0] cyc,
                                 input logic er);
        vec_t v;
        v.op = op; v.ez = ez; v.cy = cy; v.rs = rs; v.st = st; v.cyc = cyc; v.er = er;
        vq.push_back(v);
    endfunction

    // Flags flip from c3 on, so any late sampling of them shows up as a wrong state.
    task automatic add_instr(input logic [3:0] op, input logic ez, input logic cy, input int n,
                             input logic [27:0] sts, input logic sets_err);
        for (int i = 0; i < n; i++) begin
            if (sets_err && i == 3) exp_err = 1'b1;
            push(op, (i < 3) ? ez : ~ez, (i < 3) ? cy : ~cy, 1'b0, sts[27-4*i -: 4], 3'(i),
                 exp_err);
        end
    endtask

    task automatic run_vectors(input string tag);
        done_at.delete();
        for (int i = 0; i < vq.size(); i++) begin
            opcode  = vq[i].op;
            eq_zero = vq[i].ez;
            carry   = vq[i].cy;
            resume  = vq[i].rs;
            #1;
            n_vec++;
            if ({state, cycle, err, instr_done, halted} !==
                {vq[i].st, vq[i].cyc, vq[i].er, vq[i].st == S_NX, vq[i].st == S_HT}) begin
                n_bad++;
                $display("FAIL %s clk%0d: got state=%0d cycle=%0d err=%b done=%b halted=%b, want state=%0d cycle=%0d err=%b done=%b halted=%b",
                         tag, i + 1, state, cycle, err, instr_done, halted, vq[i].st,
                         vq[i].cyc, vq[i].er, vq[i].st == S_NX, vq[i].st == S_HT);
            end
            if (instr_done === 1'b1) done_at.push_back(i + 1);
            @(negedge clk);
        end
        vq.delete();
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic check_reset_vals(input string name);
        check(name, {23'd0, state, cycle, err, instr_done, halted}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b1;
        exp_err = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    int exp_done[7] = '{6, 12, 19, 26, 30, 34, 39};
    logic [3:0] wd_seq[5] = '{S_FP, S_FI, S_FP, S_LA, S_RB};

    initial begin
        reset = 1'b0; opcode = OP_NOP; eq_zero = 1'b0; carry = 1'b0; resume = 1'b0;
        #2 reset = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_vals("reset_state");
        reset = 1'b0;

        // Async reset in the middle of an ADD, then a full ADD.
        add_instr(OP_ADD, 1'b0, 1'b0, 4, {S_FP, S_FI, S_FP, S_LA, 12'h0}, 1'b0);
        run_vectors("add_pre_reset");
        check("add_at_c4", {28'd0, state}, {28'd0, S_RB});
        #2 reset = 1'b1;
        #1 check_reset_vals("async_reset_mid_add");
        @(negedge clk);
        reset = 1'b0;
        add_instr(OP_ADD, 1'b0, 1'b0, 7, {S_FP, S_FI, S_FP, S_LA, S_RB, S_AD, S_NX}, 1'b0);
        run_vectors("add_after_reset");
        check("add_done_count", done_at.size(), 1);
        if (done_at.size() == 1) check("add_done_clock", done_at[0], 7);

        // Back-to-back program.
        do_reset();
        add_instr(OP_LDA, 1'b0, 1'b0, 6, {S_FP, S_FI, S_FP, S_LA, S_RA, S_NX, 4'h0}, 1'b0);
        add_instr(OP_STA, 1'b1, 1'b0, 6, {S_FP, S_FI, S_FP, S_LA, S_SA, S_NX, 4'h0}, 1'b0);
        add_instr(OP_ADD, 1'b0, 1'b1, 7, {S_FP, S_FI, S_FP, S_LA, S_RB, S_AD, S_NX}, 1'b0);
        add_instr(OP_SUB, 1'b1, 1'b1, 7, {S_FP, S_FI, S_FP, S_LA, S_RB, S_SB, S_NX}, 1'b0);
        add_instr(OP_OUT, 1'b0, 1'b0, 4, {S_FP, S_FI, S_OA, S_NX, 12'h0}, 1'b0);
        add_instr(OP_NOP, 1'b0, 1'b0, 4, {S_FP, S_FI, S_FP, S_NX, 12'h0}, 1'b0);
        add_instr(OP_JMP, 1'b0, 1'b0, 5, {S_FP, S_FI, S_FP, S_JP, S_NX, 8'h0}, 1'b0);
        run_vectors("program");
        check("program_done_count", done_at.size(), 7);
        for (int k = 0; k < 7; k++) begin
            if (k < done_at.size()) check($sformatf("program_done_%0d", k), done_at[k],
                                          exp_done[k]);
        end

        // Conditional jumps on eq_zero.
        do_reset();
        add_instr(OP_JEZ, 1'b1, 1'b0, 5, {S_FP, S_FI, S_FP, S_JP, S_NX, 8'h0}, 1'b0);
        add_instr(OP_JEZ, 1'b0, 1'b0, 5, {S_FP, S_FI, S_FP, S_SK, S_NX, 8'h0}, 1'b0);
        add_instr(OP_JNZ, 1'b1, 1'b0, 5, {S_FP, S_FI, S_FP, S_SK, S_NX, 8'h0}, 1'b0);
        add_instr(OP_JNZ, 1'b0, 1'b0, 5, {S_FP, S_FI, S_FP, S_JP, S_NX, 8'h0}, 1'b0);
        run_vectors("cond_jump");

        // Halt for 20 clocks, then resume.
        do_reset();
        push(OP_HLT, 1'b0, 1'b0, 1'b0, S_FP, 3'd0, 1'b0);
        push(OP_HLT, 1'b0, 1'b0, 1'b0, S_FI, 3'd1, 1'b0);
        for (int i = 0; i < 20; i++) push(OP_HLT, 1'b0, 1'b0, 1'b0, S_HT, 3'd2, 1'b0);
        push(OP_HLT, 1'b0, 1'b0, 1'b1, S_HT, 3'd2, 1'b0);
        push(OP_NOP, 1'b0, 1'b0, 1'b0, S_NX, 3'd3, 1'b0);
        push(OP_NOP, 1'b0, 1'b0, 1'b0, S_FP, 3'd0, 1'b0);
        run_vectors("halt");

        // Illegal opcode: NOP timing, sticky err, cleared by reset.
        do_reset();
        add_instr(OP_BAD, 1'b0, 1'b0, 4, {S_FP, S_FI, S_FP, S_NX, 12'h0}, 1'b1);
        add_instr(OP_NOP, 1'b0, 1'b0, 4, {S_FP, S_FI, S_FP, S_NX, 12'h0}, 1'b0);
        run_vectors("illegal");
        do_reset();
        check_reset_vals("err_cleared_by_reset");

        // Watchdog at MAX_CYCLES=5 cuts an ADD short.
        opcode = OP_ADD; eq_zero = 1'b0; carry = 1'b0; resume = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("wd_c%0d", i), {24'd0, wd_state, wd_cycle, wd_err},
                  {24'd0, wd_seq[i], 3'(i), 1'b0});
            @(negedge clk);
        end
        #1;
        check("wd_forced_next", {28'd0, wd_state, wd_err, wd_done}, {28'd0, S_NX, 2'b11});
        @(negedge clk);
        #1;
        check("wd_after_next", {24'd0, wd_state, wd_cycle, wd_err}, {24'd0, S_FP, 3'd0, 1'b1});
        @(negedge clk);

        // Carry-conditioned jumps.
        do_reset();
`ifdef CPU_SEQ_CARRY_EN
        add_instr(OP_JCS, 1'b0, 1'b1, 5, {S_FP, S_FI, S_FP, S_JP, S_NX, 8'h0}, 1'b0);
        add_instr(OP_JCC, 1'b0, 1'b1, 5, {S_FP, S_FI, S_FP, S_SK, S_NX, 8'h0}, 1'b0);
`else
        add_instr(OP_JCS, 1'b0, 1'b1, 4, {S_FP, S_FI, S_FP, S_NX, 12'h0}, 1'b1);
        add_instr(OP_JCC, 1'b0, 1'b0, 4, {S_FP, S_FI, S_FP, S_NX, 12'h0}, 1'b1);
`endif
        run_vectors("carry_jump");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
